pole_iir_matrix: RTL and testbench
==================================

// Module: pole_iir_matrix
// PURPOSE
//  Parametrised successor to the 2x2 biquad pole stage. Computes the NSTATE-lane pole recursion
//  y[t+1] = M*y[t] + fir[t] in one clock, where M is an NSTATE x NSTATE signed coefficient matrix.
//  Sits after the zero/FIR stage of the high-rate biquad chain (8 samples/clk).
//  Adds a coefficient loader FSM with word counting, an atomic shadow->active update and load-error reporting.
// PARAMETERS
//  NSTATE    2    lanes / matrix dimension (1..4)
//  NBITS     24   output sample width
//  NFRAC     10   output fractional bits
//  A_BITS    30   feedback state width (Q.A_FRAC)
//  A_FRAC    13   feedback fractional bits
//  C_FRAC    27   accumulator/fir_in fractional bits; coefficients are Q4.(C_FRAC-A_FRAC)
//  CLKTYPE   "NONE"  clock-crossing tag applied to the coefficient input registers
// PORTS
//  clk              in   1            system clock
//  rst              in   1            synchronous, active-high reset
//  coeff_dat_i      in   18           signed coefficient word
//  coeff_wr_i       in   1            write coeff_dat_i into shadow bank
//  coeff_update_i   in   1            request shadow->active transfer
//  coeff_done_o     out  1            1-cycle pulse: transfer performed
//  coeff_err_o      out  1            sticky load error; cleared by rst or a successful update
//  sat_o            out  1            sticky saturation flag (see CONFIGURATION)
//  fir_in           in   48*NSTATE    lane k at [48k +: 48], signed Q.C_FRAC
//  y_out            out  NBITS*NSTATE lane k at [NBITS*k +: NBITS]
// BEHAVIOUR
//  - acc_k <= fir_k + sum_j M[k][j]*fb_j each cycle; fb_j = acc_j[C_FRAC-A_FRAC +: A_BITS].
//    Products are 18xA_BITS, summed in 48-bit two's complement (wraps at 48 bits).
//  - y_out_k <= acc_k[C_FRAC-NFRAC +: NBITS], registered.
//    Latency from fir_in to y_out is 2 clocks; the recursion loop is 1 clock.
//  - Loader FSM: IDLE -> LOAD on first wr; LOAD counts writes; entering count = NSTATE^2 -> ARMED.
//    Word k goes to shadow M[k/NSTATE][k%NSTATE] (row-major, first word = M[0][0]).
//  - ARMED & update: shadow->active in the same cycle (new M used from the next cycle),
//    coeff_done_o pulses, coeff_err_o clears, FSM -> IDLE.
//  - update in IDLE/LOAD: ignored (active unchanged), coeff_err_o<=1, FSM -> IDLE, count<=0.
//  - wr in ARMED without update: word discarded, coeff_err_o<=1, FSM stays ARMED.
//  - wr & update together in ARMED: update as above; the word becomes word 0 of the next load (-> LOAD, count=1).
//  - wr & update together in IDLE/LOAD: error path; the write is discarded.
//  - rst: acc, y_out, FSM (IDLE, count 0), coeff_done_o, coeff_err_o, sat_o -> 0.
//    Active and shadow coefficient banks keep their contents (not reset); power-up value is 0.
//    A rst mid-load discards the partial load.
// CONFIGURATION
//  POLE_IIR_SAT_EN defined: fb_j and y_out_k saturate to their signed min/max when the
//  dropped upper acc bits are not a sign extension; any saturation event sets sat_o.
//  POLE_IIR_SAT_EN undefined: plain bit-slice (wrap); sat_o tied 0.
// STRUCTURE
//  Shared package pole_iir_pkg: COEFF_W=18, ACC_W=48, loader state encoding, sat_slice function.
//  Sub-module pole_iir_coeff_loader: FSM, counter, shadow/active banks, done/err.
//  The top holds the MAC array, feedback and output registers.
// TESTING (NSTATE=2, defaults; 1.0 on fir_in = 1<<27, coeff 1.0 = 16384)
//  1 Load all-zero M, update; fir0=1<<27 for 1 cycle -> y_out lane0 = 1024 once, 2 clk later; then 0.
//  2 Load M[0][0]=8192 (0.5), rest 0; impulse as 1 -> lane0 1024,512,256,128,...; lane1 stays 0.
//  3 Load M[1][0]=16384 only; impulse on lane0 -> lane1 = 1024 one cycle after lane0 = 1024.
//  4 Write 3 words then update -> coeff_err_o=1, no done pulse, previous M still active.
//    Write 5 words -> err=1, the first 4 still apply on update and err clears.
//  5 rst asserted mid-decay of test 2 -> next cycle acc=0; y_out=0 one cycle later.
//    Coefficients are retained: a new impulse decays by 0.5 again.
//  6 M[0][0]=32767 (~2.0), constant fir0=1<<27 -> without macro lane0 wraps negative;
//    with POLE_IIR_SAT_EN lane0 holds 0x7FFFFF and sat_o=1.

Source files
------------

// File: rtl/pole_iir_pkg.sv
// Shared types and helpers for the NSTATE-lane pole recursion (pole_iir_matrix).
package pole_iir_pkg;

  localparam int COEFF_W = 18;
  localparam int ACC_W   = 48;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_ARMED = 2'd2
  } ld_state_e;

  // True when acc >>> lsb does not fit in a w-bit signed field.
  function automatic logic slice_ovf(input logic [ACC_W-1:0] acc, input int lsb, input int w);
    logic signed [ACC_W-1:0] sh_s;
    logic signed [ACC_W-1:0] ext_s;
    sh_s  = $signed(acc) >>> lsb;
    ext_s = (sh_s <<< (ACC_W - w)) >>> (ACC_W - w);
    return (ext_s != sh_s);
  endfunction

  function automatic logic [ACC_W-1:0] sat_slice(input logic [ACC_W-1:0] acc, input int lsb,
                                                 input int w, input logic sat_en);
    logic [ACC_W-1:0] max_s;
    max_s = (ACC_W'(1'b1) << (w - 32'sd1)) - ACC_W'(1'b1);
    if (sat_en && slice_ovf(acc, lsb, w)) begin
      if (acc[ACC_W-1]) begin
        return ~max_s;
      end else begin
        return max_s;
      end
    end else begin
      return $signed(acc) >>> lsb;
    end
  endfunction

endpackage

// File: rtl/pole_iir_matrix_coeff_loader.sv
// Coefficient loader: word-counting FSM filling a shadow bank, atomic shadow->active transfer.
module pole_iir_coeff_loader
  import pole_iir_pkg::*;
#(
  parameter int    NSTATE  = 2,
  parameter string CLKTYPE = "NONE"
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [COEFF_W-1:0]                coeff_dat_i,
  input  logic                              coeff_wr_i,
  input  logic                              coeff_update_i,
  output logic                              coeff_done_o,
  output logic                              coeff_err_o,
  output logic [NSTATE*NSTATE*COEFF_W-1:0]  coeff_flat_o
);

  localparam int NW    = NSTATE * NSTATE;
  localparam int CNT_W = $clog2(NW + 1);
  localparam ld_state_e FIRST_ST = (NW == 1) ? LD_ARMED : LD_LOAD;

  logic [COEFF_W-1:0] dat_s;
  logic               wr_s;
  logic               upd_s;
  ld_state_e          state_r;
  logic [CNT_W-1:0]   count_r;
  logic               done_r;
  logic               err_r;
  logic [COEFF_W-1:0] shadow_r [NW];
  logic [COEFF_W-1:0] active_r [NW];
  logic               shadow_we_s;
  logic               active_ld_s;
  logic [CNT_W-1:0]   shadow_idx_s;

  if (CLKTYPE == "NONE") begin : g_direct
    assign dat_s = coeff_dat_i;
    assign wr_s  = coeff_wr_i;
    assign upd_s = coeff_update_i;
  end else begin : g_capture
    (* async_reg = "true" *) logic [COEFF_W-1:0] dat_r;
    (* async_reg = "true" *) logic               wr_r;
    (* async_reg = "true" *) logic               upd_r;
    // Capture stage for a coefficient source in another clock domain (one extra cycle of load latency).
    always_ff @(posedge clk) begin
      if (rst) begin
        dat_r <= '0;
        wr_r  <= 1'b0;
        upd_r <= 1'b0;
      end else begin
        dat_r <= coeff_dat_i;
        wr_r  <= coeff_wr_i;
        upd_r <= coeff_update_i;
      end
    end
    assign dat_s = dat_r;
    assign wr_s  = wr_r;
    assign upd_s = upd_r;
  end

  // Bank write enables; a write alongside an update in ARMED starts the next load at word 0.
  always_comb begin
    shadow_we_s  = 1'b0;
    active_ld_s  = 1'b0;
    shadow_idx_s = count_r;
    if (rst) begin
      shadow_we_s = 1'b0;
    end else if (state_r == LD_ARMED) begin
      active_ld_s  = upd_s;
      shadow_we_s  = wr_s & upd_s;
      shadow_idx_s = '0;
    end else begin
      shadow_we_s = wr_s & ~upd_s;
    end
  end

  // Coefficient banks are deliberately not reset so a filter reset keeps its tuning.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NW; i++) begin
      if (shadow_we_s && (shadow_idx_s == CNT_W'(i))) begin
        shadow_r[i] <= dat_s;
      end
      if (active_ld_s) begin
        active_r[i] <= shadow_r[i];
      end
    end
  end

  // Loader FSM with registered done/err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= LD_IDLE;
      count_r <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        LD_IDLE, LD_LOAD: begin
          if (upd_s) begin
            err_r   <= 1'b1;
            state_r <= LD_IDLE;
            count_r <= '0;
          end else if (wr_s) begin
            count_r <= count_r + CNT_W'(1'b1);
            state_r <= ((count_r + CNT_W'(1'b1)) == CNT_W'(NW)) ? LD_ARMED : LD_LOAD;
          end
        end
        LD_ARMED: begin
          if (upd_s) begin
            done_r <= 1'b1;
            err_r  <= 1'b0;
            if (wr_s) begin
              count_r <= CNT_W'(1'b1);
              state_r <= FIRST_ST;
            end else begin
              count_r <= '0;
              state_r <= LD_IDLE;
            end
          end else if (wr_s) begin
            err_r <= 1'b1;
          end
        end
        default: begin
          state_r <= LD_IDLE;
          count_r <= '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NW; i++) begin : g_flat
    assign coeff_flat_o[i*COEFF_W +: COEFF_W] = active_r[i];
  end

  assign coeff_done_o = done_r;
  assign coeff_err_o  = err_r;

endmodule

// File: rtl/pole_iir_matrix.sv
// NSTATE-lane pole recursion y[t+1] = M*y[t] + fir[t], one clock per step.
// Optional POLE_IIR_SAT_EN: saturate feedback/output slices and report via sat_o.
module pole_iir_matrix
  import pole_iir_pkg::*;
#(
  parameter int    NSTATE  = 2,
  parameter int    NBITS   = 24,
  parameter int    NFRAC   = 10,
  parameter int    A_BITS  = 30,
  parameter int    A_FRAC  = 13,
  parameter int    C_FRAC  = 27,
  parameter string CLKTYPE = "NONE"
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [COEFF_W-1:0]        coeff_dat_i,
  input  logic                      coeff_wr_i,
  input  logic                      coeff_update_i,
  output logic                      coeff_done_o,
  output logic                      coeff_err_o,
  output logic                      sat_o,
  input  logic [ACC_W*NSTATE-1:0]   fir_in,
  output logic [NBITS*NSTATE-1:0]   y_out
);

  localparam int FB_LSB = C_FRAC - A_FRAC;
  localparam int Y_LSB  = C_FRAC - NFRAC;
`ifdef POLE_IIR_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic [NSTATE*NSTATE*COEFF_W-1:0] coeff_flat_s;
  logic signed [ACC_W-1:0]          acc_r [NSTATE];
  logic signed [ACC_W-1:0]          sum_s [NSTATE];
  logic signed [A_BITS-1:0]         fb_s  [NSTATE];
  logic [NBITS*NSTATE-1:0]          y_r;

  pole_iir_coeff_loader #(
    .NSTATE  (NSTATE),
    .CLKTYPE (CLKTYPE)
  ) u_loader (
    .clk            (clk),
    .rst            (rst),
    .coeff_dat_i    (coeff_dat_i),
    .coeff_wr_i     (coeff_wr_i),
    .coeff_update_i (coeff_update_i),
    .coeff_done_o   (coeff_done_o),
    .coeff_err_o    (coeff_err_o),
    .coeff_flat_o   (coeff_flat_s)
  );

  // MAC array: products are 18 x A_BITS, accumulated with 48-bit wrap.
  always_comb begin
    for (int j = 0; j < NSTATE; j++) begin
      fb_s[j] = A_BITS'(sat_slice(acc_r[j], FB_LSB, A_BITS, SAT_EN));
    end
    for (int k = 0; k < NSTATE; k++) begin
      sum_s[k] = $signed(fir_in[ACC_W*k +: ACC_W]);
      for (int j = 0; j < NSTATE; j++) begin
        sum_s[k] = sum_s[k]
                 + ACC_W'($signed(coeff_flat_s[(k*NSTATE+j)*COEFF_W +: COEFF_W]))
                 * ACC_W'(fb_s[j]);
      end
    end
  end

  // Recursion state and registered output slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTATE; k++) begin
        acc_r[k] <= '0;
      end
      y_r <= '0;
    end else begin
      for (int k = 0; k < NSTATE; k++) begin
        acc_r[k]              <= sum_s[k];
        y_r[NBITS*k +: NBITS] <= NBITS'(sat_slice(acc_r[k], Y_LSB, NBITS, SAT_EN));
      end
    end
  end

  assign y_out = y_r;

`ifdef POLE_IIR_SAT_EN
  logic sat_r;
  logic ovf_s;

  // Any lane whose feedback or output slice clips this cycle.
  always_comb begin
    ovf_s = 1'b0;
    for (int k = 0; k < NSTATE; k++) begin
      ovf_s = ovf_s | slice_ovf(acc_r[k], FB_LSB, A_BITS) | slice_ovf(acc_r[k], Y_LSB, NBITS);
    end
  end

  // Sticky saturation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_r <= 1'b0;
    end else begin
      sat_r <= sat_r | ovf_s;
    end
  end

  assign sat_o = sat_r;
`else
  assign sat_o = 1'b0;
`endif

endmodule

// File: tb/tb_pole_iir_matrix.sv
// Directed self-checking bench for pole_iir_matrix (NSTATE=2, default widths).
module tb_pole_iir_matrix;

  logic        clk;
  logic        rst;
  logic [17:0] coeff_dat_i;
  logic        coeff_wr_i;
  logic        coeff_update_i;
  logic        coeff_done_o;
  logic        coeff_err_o;
  logic        sat_o;
  logic [95:0] fir_in;
  logic [47:0] y_out;

  logic signed [23:0] y0_s;
  logic signed [23:0] y1_s;
  assign y0_s = y_out[23:0];
  assign y1_s = y_out[47:24];

  int errors;
  int checks;

  localparam logic [47:0] ONE = 48'h000008000000;

  pole_iir_matrix dut (
    .clk            (clk),
    .rst            (rst),
    .coeff_dat_i    (coeff_dat_i),
    .coeff_wr_i     (coeff_wr_i),
    .coeff_update_i (coeff_update_i),
    .coeff_done_o   (coeff_done_o),
    .coeff_err_o    (coeff_err_o),
    .sat_o          (sat_o),
    .fir_in         (fir_in),
    .y_out          (y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wr_word(input logic [17:0] d);
    coeff_dat_i = d;
    coeff_wr_i  = 1'b1;
    tick();
    coeff_wr_i  = 1'b0;
  endtask

  task automatic load4(input logic [17:0] a, input logic [17:0] b, input logic [17:0] c, input logic [17:0] d);
    wr_word(a);
    wr_word(b);
    wr_word(c);
    wr_word(d);
    coeff_update_i = 1'b1;
    tick();
    coeff_update_i = 1'b0;
  endtask

  task automatic impulse0();
    fir_in[47:0] = ONE;
    tick();
    fir_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (y_out !== 48'd0) begin errors++; $display("FAIL reset_y: got %h expected 0", y_out); end
    checks++;
    if (coeff_done_o !== 1'b0 || coeff_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got done=%b err=%b expected 0 0", coeff_done_o, coeff_err_o);
    end
    checks++;
    if (sat_o !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat_o); end
    rst = 1'b0;
  endtask

  task automatic test_zero_matrix();
    load4(18'd0, 18'd0, 18'd0, 18'd0);
    checks++;
    if (coeff_done_o !== 1'b1 || coeff_err_o !== 1'b0) begin
      errors++; $display("FAIL zero_load_done: got done=%b err=%b expected 1 0", coeff_done_o, coeff_err_o);
    end
    tick();
    checks++;
    if (coeff_done_o !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", coeff_done_o); end
    impulse0();
    checks++;
    if (y0_s !== 24'sd0) begin errors++; $display("FAIL zero_lat1: got %0d expected 0", y0_s); end
    tick();
    checks++;
    if (y0_s !== 24'sd1024 || y1_s !== 24'sd0) begin
      errors++; $display("FAIL zero_lat2: got %0d/%0d expected 1024/0", y0_s, y1_s);
    end
    tick();
    checks++;
    if (y0_s !== 24'sd0) begin errors++; $display("FAIL zero_after: got %0d expected 0", y0_s); end
  endtask

  task automatic test_decay();
    load4(18'd8192, 18'd0, 18'd0, 18'd0);
    reset_pulse();
    impulse0();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (int'(y0_s) !== (1024 >> i) || y1_s !== 24'sd0) begin
        errors++; $display("FAIL decay[%0d]: got %0d/%0d expected %0d/0", i, y0_s, y1_s, 1024 >> i);
      end
    end
  endtask

  task automatic test_cross();
    load4(18'd0, 18'd0, 18'd16384, 18'd0);
    reset_pulse();
    impulse0();
    tick();
    checks++;
    if (y0_s !== 24'sd1024 || y1_s !== 24'sd0) begin
      errors++; $display("FAIL cross_t0: got %0d/%0d expected 1024/0", y0_s, y1_s);
    end
    tick();
    checks++;
    if (y0_s !== 24'sd0 || y1_s !== 24'sd1024) begin
      errors++; $display("FAIL cross_t1: got %0d/%0d expected 0/1024", y0_s, y1_s);
    end
    tick();
    checks++;
    if (y1_s !== 24'sd0) begin errors++; $display("FAIL cross_t2: got %0d expected 0", y1_s); end
  endtask

  task automatic test_load_errors();
    reset_pulse();
    wr_word(18'd8192);
    wr_word(18'd0);
    wr_word(18'd0);
    coeff_update_i = 1'b1;
    tick();
    coeff_update_i = 1'b0;
    checks++;
    if (coeff_err_o !== 1'b1 || coeff_done_o !== 1'b0) begin
      errors++; $display("FAIL short_load: got err=%b done=%b expected 1 0", coeff_err_o, coeff_done_o);
    end
    impulse0();
    tick();
    tick();
    checks++;
    if (y0_s !== 24'sd0 || y1_s !== 24'sd1024) begin
      errors++; $display("FAIL short_load_keeps_m: got %0d/%0d expected 0/1024", y0_s, y1_s);
    end
    reset_pulse();
    wr_word(18'd8192);
    wr_word(18'd0);
    wr_word(18'd0);
    wr_word(18'd0);
    checks++;
    if (coeff_err_o !== 1'b0) begin errors++; $display("FAIL armed_no_err: got %b expected 0", coeff_err_o); end
    wr_word(18'd16384);
    checks++;
    if (coeff_err_o !== 1'b1) begin errors++; $display("FAIL extra_word_err: got %b expected 1", coeff_err_o); end
    coeff_update_i = 1'b1;
    tick();
    coeff_update_i = 1'b0;
    checks++;
    if (coeff_done_o !== 1'b1 || coeff_err_o !== 1'b0) begin
      errors++; $display("FAIL extra_word_update: got done=%b err=%b expected 1 0", coeff_done_o, coeff_err_o);
    end
    impulse0();
    tick();
    tick();
    checks++;
    if (y0_s !== 24'sd512 || y1_s !== 24'sd0) begin
      errors++; $display("FAIL extra_word_m: got %0d/%0d expected 512/0", y0_s, y1_s);
    end
  endtask

  task automatic test_reset_mid_decay();
    reset_pulse();
    impulse0();
    tick();
    tick();
    checks++;
    if (y0_s !== 24'sd512) begin errors++; $display("FAIL mid_pre: got %0d expected 512", y0_s); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (y_out !== 48'd0) begin errors++; $display("FAIL mid_rst_y: got %h expected 0", y_out); end
    tick();
    checks++;
    if (y_out !== 48'd0) begin errors++; $display("FAIL mid_rst_acc: got %h expected 0", y_out); end
    impulse0();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (int'(y0_s) !== (1024 >> i)) begin
        errors++; $display("FAIL mid_retained[%0d]: got %0d expected %0d", i, y0_s, 1024 >> i);
      end
    end
  endtask

  task automatic test_back_to_back();
    reset_pulse();
    wr_word(18'd0);
    wr_word(18'd0);
    wr_word(18'd0);
    wr_word(18'd0);
    coeff_dat_i    = 18'd8192;
    coeff_wr_i     = 1'b1;
    coeff_update_i = 1'b1;
    tick();
    coeff_wr_i     = 1'b0;
    coeff_update_i = 1'b0;
    checks++;
    if (coeff_done_o !== 1'b1 || coeff_err_o !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got done=%b err=%b expected 1 0", coeff_done_o, coeff_err_o);
    end
    wr_word(18'd0);
    wr_word(18'd0);
    wr_word(18'd0);
    coeff_update_i = 1'b1;
    tick();
    coeff_update_i = 1'b0;
    checks++;
    if (coeff_done_o !== 1'b1 || coeff_err_o !== 1'b0) begin
      errors++; $display("FAIL b2b_second: got done=%b err=%b expected 1 0", coeff_done_o, coeff_err_o);
    end
    impulse0();
    tick();
    tick();
    checks++;
    if (y0_s !== 24'sd512) begin errors++; $display("FAIL b2b_carry_word: got %0d expected 512", y0_s); end
  endtask

  task automatic test_growth();
    load4(18'd32767, 18'd0, 18'd0, 18'd0);
    reset_pulse();
    fir_in[47:0] = ONE;
    tick();
    checks++;
    if (y0_s !== 24'sd0) begin errors++; $display("FAIL grow_t0: got %0d expected 0", y0_s); end
    tick();
    checks++;
    if (y0_s !== 24'sd1024) begin errors++; $display("FAIL grow_t1: got %0d expected 1024", y0_s); end
    tick();
    checks++;
    if (y0_s !== 24'sd3071) begin errors++; $display("FAIL grow_t2: got %0d expected 3071", y0_s); end
`ifdef POLE_IIR_SAT_EN
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (y0_s !== 24'sh7FFFFF || sat_o !== 1'b1) begin
      errors++; $display("FAIL grow_sat: got y=%h sat=%b expected 7fffff 1", y0_s, sat_o);
    end
`else
    begin
      logic saw_neg;
      saw_neg = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (y0_s < 0) saw_neg = 1'b1;
      end
      checks++;
      if (saw_neg !== 1'b1) begin errors++; $display("FAIL grow_wrap: got saw_neg=%b expected 1", saw_neg); end
      checks++;
      if (sat_o !== 1'b0) begin errors++; $display("FAIL grow_sat_off: got %b expected 0", sat_o); end
    end
`endif
    fir_in = '0;
    reset_pulse();
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    rst            = 1'b1;
    coeff_dat_i    = '0;
    coeff_wr_i     = 1'b0;
    coeff_update_i = 1'b0;
    fir_in         = '0;
    test_reset();
    test_zero_matrix();
    test_decay();
    test_cross();
    test_load_errors();
    test_reset_mid_decay();
    test_back_to_back();
    test_growth();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
